// File: rtl/upcount_sequencer_if.sv
// rtl/upcount_sequencer_if.sv - control/status bundle between a run requester and upcount_sequencer
interface upcount_sequencer_if #(
  parameter int WIDTH  = 3,
  parameter int PASS_W = 4
);
  logic              start;
  logic              pause;
  logic              abort;
  logic [WIDTH-1:0]  term_val;
  logic [PASS_W-1:0] passes;
  logic [WIDTH-1:0]  count;
  logic [PASS_W-1:0] pass_idx;
  logic              busy;
  logic              wrap;
  logic              done;

  modport master (
    output start, pause, abort, term_val, passes,
    input  count, pass_idx, busy, wrap, done
  );

  modport slave (
    input  start, pause, abort, term_val, passes,
    output count, pass_idx, busy, wrap, done
  );
endinterface

// File: rtl/upcount_sequencer.sv
// rtl/upcount_sequencer.sv - runs a 0..term counter for a fixed number of passes
module upcount_sequencer #(
  parameter int WIDTH  = 3,
  parameter int PASS_W = 4
) (
  input  logic clk,
  input  logic reset,
  upcount_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  term_q, term_n;
  logic [PASS_W-1:0] passes_q, passes_n;
  logic [WIDTH-1:0]  count_q, count_n;
  logic [PASS_W-1:0] pass_q, pass_n;
  logic [PASS_W-1:0] pass_inc;
  logic              busy_q, busy_n;
  logic              wrap_q, wrap_n;
  logic              done_q, done_n;

  assign pass_inc = pass_q + PASS_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      term_q   <= '0;
      passes_q <= '0;
      count_q  <= '0;
      pass_q   <= '0;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      term_q   <= term_n;
      passes_q <= passes_n;
      count_q  <= count_n;
      pass_q   <= pass_n;
      busy_q   <= busy_n;
      wrap_q   <= wrap_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    term_n   = term_q;
    passes_n = passes_q;
    count_n  = count_q;
    pass_n   = pass_q;
    busy_n   = busy_q;
    wrap_n   = 1'b0;
    done_n   = 1'b0;
    case (state)
      IDLE, DONE: begin
        // abort is meaningless outside a run, so only start matters here
        if (bus.start) begin
          term_n   = bus.term_val;
          passes_n = bus.passes;
          count_n  = '0;
          pass_n   = '0;
          if (bus.passes == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n = RUN;
            busy_n  = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_n = IDLE;
          count_n = '0;
          pass_n  = '0;
          busy_n  = 1'b0;
        end else if (bus.pause) begin
          state_n = PAUSE;
        end else if (count_q != term_q) begin
          count_n = count_q + WIDTH'(1);
        end else begin
          count_n = '0;
          pass_n  = pass_inc;
          wrap_n  = 1'b1;
          if (pass_inc == passes_q) begin
            state_n = DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end
        end
      end
      PAUSE: begin
        // leaving PAUSE costs one held cycle before counting resumes
        if (bus.abort) begin
          state_n = IDLE;
          count_n = '0;
          pass_n  = '0;
          busy_n  = 1'b0;
        end else if (!bus.pause) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
        pass_n  = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.count    = count_q;
  assign bus.pass_idx = pass_q;
  assign bus.busy     = busy_q;
  assign bus.wrap     = wrap_q;
  assign bus.done     = done_q;
endmodule
